// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding, default widths and drain-counter sizing for run_ctrl
package run_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ARM, RUN, FINISH, DONE} state_t;
  localparam int CNT_W_DEF = 16;
  function automatic int drain_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/run_ctrl_sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  // clear wins over increment; increment stops once every bit is set
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: start/halt run sequencer with drain delay and cycle counter; RUN_TIMEOUT_EN adds a watchdog
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DRAIN_CYCLES = 2
`ifdef RUN_TIMEOUT_EN
  , parameter int unsigned MAX_CYCLES = 32'hFFFF
`endif
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic             halt,
  output logic             run_en,
  output logic             pc_reset,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic             timeout
);
  localparam int DRAIN_W = drain_w(DRAIN_CYCLES);
  state_t state, next;
  logic [DRAIN_W-1:0] drain;
  logic drain_last, wd;
  assign drain_last = (drain == DRAIN_W'(DRAIN_CYCLES - 1));
`ifdef RUN_TIMEOUT_EN
  assign wd = (cycle_count == CNT_W'(MAX_CYCLES - 1));
  // timeout latches when the watchdog, not halt, ends the run; a new arm clears it
  always_ff @(posedge CLK)
    if (Reset || next == ARM) timeout <= 1'b0;
    else if (state == RUN && next == DONE && !halt) timeout <= 1'b1;
`else
  assign wd = 1'b0;
  assign timeout = 1'b0;
`endif
  // next state: start always re-arms, halt beats the watchdog, zero drain skips FINISH
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? ARM : IDLE;
      ARM:     next = start ? ARM : RUN;
      RUN:     next = start ? ARM : halt ? ((DRAIN_CYCLES == 0) ? DONE : FINISH) : wd ? DONE : RUN;
      FINISH:  next = start ? ARM : drain_last ? DONE : FINISH;
      DONE:    next = start ? ARM : DONE;
      default: next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge CLK)
    if (Reset) state <= IDLE;
    else state <= next;
  // drain counter restarts at zero on every entry into FINISH
  always_ff @(posedge CLK)
    if (Reset || state != FINISH) drain <= '0;
    else drain <= drain + 1'b1;
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (CLK),
    .rst (Reset),
    .clr (next == ARM),
    .inc (state == RUN && next != ARM),
    .q   (cycle_count)
  );
  assign run_en   = (state == RUN);
  assign pc_reset = (state == IDLE) || (state == ARM);
  assign done     = (state == DONE);
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed per-cycle scoreboard for run_ctrl (nominal drain and zero-drain/narrow-counter instances)
module tb_run_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic start = 1'b0, halt = 1'b0, rst_a = 1'b1, rst_b = 1'b1;
  logic a_run_en, a_pc_reset, a_done, a_timeout;
  logic b_run_en, b_pc_reset, b_done, b_timeout;
  logic [15:0] a_cnt;
  logic [3:0] b_cnt;
  run_ctrl u_a (
    .CLK(clk), .Reset(rst_a), .start(start), .halt(halt),
    .run_en(a_run_en), .pc_reset(a_pc_reset), .done(a_done),
    .cycle_count(a_cnt), .timeout(a_timeout)
  );
  run_ctrl #(.CNT_W(4), .DRAIN_CYCLES(0)
`ifdef RUN_TIMEOUT_EN
    , .MAX_CYCLES(8)
`endif
  ) u_b (
    .CLK(clk), .Reset(rst_b), .start(start), .halt(halt),
    .run_en(b_run_en), .pc_reset(b_pc_reset), .done(b_done),
    .cycle_count(b_cnt), .timeout(b_timeout)
  );
  typedef struct {
    logic sel;
    logic re, pr, dn, to;
    logic [15:0] cnt;
    string nm;
  } exp_t;
  exp_t sbq[$];
  int checks = 0, errors = 0;
  task automatic step(input int sel, r, s, h, re, pr, dn, cnt, to, input string nm);
    exp_t e;
    @(negedge clk);
    rst_a = (sel != 0) ? 1'b1 : (r != 0);
    rst_b = (sel != 0) ? (r != 0) : 1'b1;
    start = (s != 0);
    halt  = (h != 0);
    e.sel = (sel != 0);
    e.re  = (re != 0);
    e.pr  = (pr != 0);
    e.dn  = (dn != 0);
    e.to  = (to != 0);
    e.cnt = 16'(cnt);
    e.nm  = nm;
    sbq.push_back(e);
  endtask
  task automatic ta(input int r, s, h, re, pr, dn, cnt, input string nm);
    step(0, r, s, h, re, pr, dn, cnt, 0, nm);
  endtask
  task automatic tb(input int r, s, h, re, pr, dn, cnt, to, input string nm);
    step(1, r, s, h, re, pr, dn, cnt, to, nm);
  endtask
  initial forever begin
    exp_t e;
    logic re, pr, dn, to;
    logic [15:0] ac;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e  = sbq.pop_front();
      re = e.sel ? b_run_en : a_run_en;
      pr = e.sel ? b_pc_reset : a_pc_reset;
      dn = e.sel ? b_done : a_done;
      to = e.sel ? b_timeout : a_timeout;
      ac = e.sel ? {12'd0, b_cnt} : a_cnt;
      checks++;
      if (re !== e.re || pr !== e.pr || dn !== e.dn || to !== e.to || ac !== e.cnt) begin
        errors++;
        $display("FAIL %s: got run_en=%b pc_reset=%b done=%b count=%0d timeout=%b, want run_en=%b pc_reset=%b done=%b count=%0d timeout=%b",
                 e.nm, re, pr, dn, ac, to, e.re, e.pr, e.dn, e.cnt, e.to);
      end
    end
  end
  initial begin
    ta(1, 0, 0, 0, 1, 0, 0, "reset");
    ta(1, 0, 1, 0, 1, 0, 0, "reset_halt");
    ta(0, 0, 1, 0, 1, 0, 0, "idle_halt_ignored");
    ta(0, 1, 0, 0, 1, 0, 0, "arm1");
    ta(0, 1, 0, 0, 1, 0, 0, "arm2");
    ta(0, 0, 0, 1, 0, 0, 0, "launch");
    for (int i = 1; i <= 4; i++) ta(0, 0, 0, 1, 0, 0, i, "run");
    ta(0, 0, 1, 0, 0, 0, 5, "halt_edge");
    ta(0, 0, 0, 0, 0, 0, 5, "drain1");
    ta(0, 0, 0, 0, 0, 1, 5, "done");
    for (int i = 0; i < 10; i++) ta(0, 0, i % 2, 0, 0, 1, 5, "done_hold");
    ta(0, 1, 0, 0, 1, 0, 0, "relaunch_arm");
    ta(0, 0, 0, 1, 0, 0, 0, "run2");
    for (int i = 1; i <= 3; i++) ta(0, 0, 0, 1, 0, 0, i, "run2_cnt");
    ta(0, 1, 0, 0, 1, 0, 0, "abort");
    ta(0, 0, 0, 1, 0, 0, 0, "run3");
    ta(0, 0, 0, 1, 0, 0, 1, "run3_from1");
    ta(0, 1, 1, 0, 1, 0, 0, "start_beats_halt");
    ta(0, 0, 0, 1, 0, 0, 0, "run4");
    ta(0, 0, 0, 1, 0, 0, 1, "run4_cnt");
    ta(0, 0, 1, 0, 0, 0, 2, "run4_halt");
    ta(0, 0, 0, 0, 0, 0, 2, "finish");
    ta(1, 0, 0, 0, 1, 0, 0, "reset_mid_finish");
    ta(0, 0, 0, 0, 1, 0, 0, "idle_after_reset");
    tb(1, 0, 0, 0, 1, 0, 0, 0, "b_reset");
    tb(0, 1, 0, 0, 1, 0, 0, 0, "b_arm");
    tb(0, 0, 0, 1, 0, 0, 0, 0, "b_launch");
    tb(0, 0, 1, 0, 0, 1, 1, 0, "zero_drain_done");
    tb(0, 0, 0, 0, 0, 1, 1, 0, "b_done_hold");
    tb(0, 1, 0, 0, 1, 0, 0, 0, "b_rearm");
    tb(0, 0, 0, 1, 0, 0, 0, 0, "b_run");
`ifdef RUN_TIMEOUT_EN
    for (int i = 1; i <= 7; i++) tb(0, 0, 0, 1, 0, 0, i, 0, "wd_run");
    tb(0, 0, 0, 0, 0, 1, 8, 1, "watchdog");
    tb(0, 0, 0, 0, 0, 1, 8, 1, "wd_hold");
    tb(0, 1, 0, 0, 1, 0, 0, 0, "wd_clear");
`else
    for (int i = 1; i <= 20; i++) tb(0, 0, 0, 1, 0, 0, (i > 15) ? 15 : i, 0, "saturate");
    tb(0, 1, 0, 0, 1, 0, 0, 0, "sat_clear");
`endif
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_queue: got %0d pending, want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
